div_seq: RTL and testbench

Sequencer for the GPU's iterative divide unit. It accepts DIV issue and the divide-control write from the GPU pipeline, generates the load and per-step strobes that drive the divider datapath, and arbitrates the quotient writeback onto the shared register write port. It also produces the pipeline stall terms for a second DIV or a remainder read issued while a divide is in flight.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step_cnt.sv | 37 +++
 rtl/div_seq.sv | 88 ++++++++
 tb/tb_div_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the GPU divide sequencer.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      WB   = 2'd3
   } div_state_t;

   localparam int unsigned DIV_STEPS_DEF      = 16;
   localparam int unsigned DIVCTRL_OFFSET_BIT = 0;

endpackage

// File: rtl/div_step_cnt.sv
// Loadable down-counter for iterative divide sequencers.
// Decrement saturates at zero so the count holds 0 once a divide is finished.
module div_step_cnt #(
   parameter int unsigned CW = 5
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          dec_i,
   output logic [CW-1:0] cnt_o,
   output logic          zero_o
);

   logic [CW-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/div_seq.sv
// Sequencer for the GPU iterative divider: load/step strobes, quotient
// writeback handshake and pipeline stall terms for DIV and remainder reads.
module div_seq
   import div_pkg::*;
#(
   parameter int unsigned STEPS = DIV_STEPS_DEF,
   parameter int unsigned CW    = 5
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          div_start,
   input  logic          divwr,
   input  logic [31:0]   gpu_din,
   input  logic          remrd,
   input  logic          wb_gnt,
   output logic          div_load,
   output logic          div_step,
   output logic          div_offset,
   output logic [CW-1:0] div_cnt,
   output logic          div_active,
   output logic          wb_req,
   output logic          div_done,
   output logic          start_stall,
   output logic          rem_stall
);

   div_state_t state_d, state_q;
   logic       ctrl_d, ctrl_q;
   logic       offset_d, offset_q;
   logic       cnt_zero;
   logic       wb_accept;
   logic       unused_din;

   assign unused_din = ^gpu_din;
   assign wb_accept  = (state_q == WB) && wb_gnt;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (div_start) state_d = LOAD;
         LOAD:    state_d = RUN;
         RUN:     if (cnt_zero) state_d = WB;
         WB:      if (wb_gnt) state_d = div_start ? LOAD : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control bit is live immediately; the divide only sees it when LOAD samples it.
   always_comb begin
      ctrl_d   = divwr ? gpu_din[DIVCTRL_OFFSET_BIT] : ctrl_q;
      offset_d = (state_q == LOAD) ? ctrl_q : offset_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         ctrl_q   <= 1'b0;
         offset_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         offset_q <= offset_d;
      end
   end

   div_step_cnt #(
      .CW(CW)
   ) u_step_cnt (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .load_i     (state_q == LOAD),
      .load_val_i (CW'(STEPS - 1)),
      .dec_i      (state_q == RUN),
      .cnt_o      (div_cnt),
      .zero_o     (cnt_zero)
   );

   assign div_load    = (state_q == LOAD);
   assign div_step    = (state_q == RUN);
   assign wb_req      = (state_q == WB);
   assign div_active  = (state_q != IDLE);
   assign div_offset  = offset_q;
   assign div_done    = wb_accept;
   assign start_stall = div_start && div_active && !wb_accept;
   // Remainder becomes readable in the cycle the quotient writeback is granted.
   assign rem_stall   = remrd && div_active && !wb_accept;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, corner-case
// sequences and a randomized run against a timeline-based reference model.
module tb_div_seq;

   localparam int STEPS = 16;
   localparam int CW    = 5;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          div_start, divwr, remrd, wb_gnt;
   logic [31:0]   gpu_din;
   logic          div_load, div_step, div_offset, div_active;
   logic          wb_req, div_done, start_stall, rem_stall;
   logic [CW-1:0] div_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: a divide is described by its age in cycles since it was
   // accepted (1 = load cycle, 2..STEPS+1 = steps, STEPS+2 = writeback).
   bit m_active;
   int m_age;
   bit m_ctrl, m_off;

   always #5 clk = ~clk;

   div_seq #(
      .STEPS(STEPS),
      .CW   (CW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .div_start   (div_start),
      .divwr       (divwr),
      .gpu_din     (gpu_din),
      .remrd       (remrd),
      .wb_gnt      (wb_gnt),
      .div_load    (div_load),
      .div_step    (div_step),
      .div_offset  (div_offset),
      .div_cnt     (div_cnt),
      .div_active  (div_active),
      .wb_req      (wb_req),
      .div_done    (div_done),
      .start_stall (start_stall),
      .rem_stall   (rem_stall)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_age    = 0;
      m_ctrl   = 1'b0;
      m_off    = 1'b0;
   endtask

   task automatic check_model();
      bit e_wb, e_acc;
      int e_cnt;
      e_wb  = m_active && (m_age >= STEPS + 2);
      e_acc = e_wb && (wb_gnt === 1'b1);
      e_cnt = (m_active && m_age >= 2 && m_age <= STEPS + 1) ? STEPS + 1 - m_age : 0;
      chk("m_load",   32'(div_load),    32'(m_active && m_age == 1));
      chk("m_step",   32'(div_step),    32'(m_active && m_age >= 2 && m_age <= STEPS + 1));
      chk("m_cnt",    32'(div_cnt),     32'(e_cnt));
      chk("m_active", 32'(div_active),  32'(m_active));
      chk("m_wbreq",  32'(wb_req),      32'(e_wb));
      chk("m_done",   32'(div_done),    32'(e_acc));
      chk("m_offset", 32'(div_offset),  32'(m_off));
      chk("m_sstall", 32'(start_stall), 32'(div_start && m_active && !e_acc));
      chk("m_rstall", 32'(rem_stall),   32'(remrd && m_active && !e_acc));
   endtask

   task automatic model_update();
      bit acc;
      if (!reset_n) begin
         model_reset();
         return;
      end
      acc = m_active && (m_age >= STEPS + 2) && wb_gnt;
      if (m_active && m_age == 1) m_off = m_ctrl;
      if (divwr) m_ctrl = gpu_din[0];
      if (acc) begin
         m_active = div_start;
         m_age    = 1;
      end else if (m_active) begin
         if (m_age < STEPS + 2) m_age++;
      end else if (div_start) begin
         m_active = 1'b1;
         m_age    = 1;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      check_model();
   endtask

   task automatic adv();
      @(posedge clk);
      model_update();
      #1;
   endtask

   typedef struct {
      int cyc;
      bit load, step;
      int cnt;
      bit active, wbreq, done;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int steps_seen, lat;
      bit found;

      tbl[0] = '{cyc: 0,  load: 0, step: 0, cnt: 0,  active: 0, wbreq: 0, done: 0};
      tbl[1] = '{cyc: 1,  load: 1, step: 0, cnt: 0,  active: 1, wbreq: 0, done: 0};
      tbl[2] = '{cyc: 2,  load: 0, step: 1, cnt: 15, active: 1, wbreq: 0, done: 0};
      tbl[3] = '{cyc: 9,  load: 0, step: 1, cnt: 8,  active: 1, wbreq: 0, done: 0};
      tbl[4] = '{cyc: 17, load: 0, step: 1, cnt: 0,  active: 1, wbreq: 0, done: 0};
      tbl[5] = '{cyc: 18, load: 0, step: 0, cnt: 0,  active: 1, wbreq: 1, done: 1};
      tbl[6] = '{cyc: 19, load: 0, step: 0, cnt: 0,  active: 0, wbreq: 0, done: 0};

      reset_n = 1'b0; div_start = 1'b0; divwr = 1'b0; remrd = 1'b0; wb_gnt = 1'b0;
      gpu_din = '0;
      model_reset();
      sample();
      adv();
      sample();
      chk("reset_active", 32'(div_active), 32'd0);
      chk("reset_cnt",    32'(div_cnt),    32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Single divide against the vector table.
      wb_gnt     = 1'b1;
      steps_seen = 0;
      for (int c = 0; c < 20; c++) begin
         div_start = (c == 0);
         sample();
         if (div_step) steps_seen++;
         for (int k = 0; k < 7; k++) begin
            if (tbl[k].cyc == c) begin
               chk($sformatf("t%0d_load", c),   32'(div_load),   32'(tbl[k].load));
               chk($sformatf("t%0d_step", c),   32'(div_step),   32'(tbl[k].step));
               chk($sformatf("t%0d_cnt", c),    32'(div_cnt),    32'(tbl[k].cnt));
               chk($sformatf("t%0d_active", c), 32'(div_active), 32'(tbl[k].active));
               chk($sformatf("t%0d_wbreq", c),  32'(wb_req),     32'(tbl[k].wbreq));
               chk($sformatf("t%0d_done", c),   32'(div_done),   32'(tbl[k].done));
            end
         end
         adv();
      end
      chk("single_steps", 32'(steps_seen), 32'(STEPS));

      // Offset mode: bit latched at LOAD, mid-run write affects the next divide only.
      divwr = 1'b1; gpu_din = 32'h0000_0001;
      sample(); adv();
      divwr = 1'b0; gpu_din = 32'h0;
      for (int c = 0; c < 19; c++) begin
         div_start = (c == 0);
         divwr     = (c == 5);
         sample();
         if (c >= 2) chk($sformatf("off1_c%0d", c), 32'(div_offset), 32'd1);
         adv();
      end
      divwr = 1'b0;
      for (int c = 0; c < 4; c++) begin
         div_start = (c == 0);
         sample();
         if (c >= 2) chk($sformatf("off0_c%0d", c), 32'(div_offset), 32'd0);
         adv();
      end
      div_start = 1'b0;
      for (int c = 0; c < 20; c++) begin sample(); adv(); end

      // Writeback backpressure.
      wb_gnt = 1'b0; div_start = 1'b1;
      found  = 1'b0;
      for (int c = 0; c < 40; c++) begin
         sample();
         if (wb_req) begin found = 1'b1; break; end
         adv();
         div_start = 1'b0;
      end
      chk("bp_reach_wb", 32'(found), 32'd1);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) sample();
         chk($sformatf("bp_req_c%0d", c),  32'(wb_req),   32'd1);
         chk($sformatf("bp_done_c%0d", c), 32'(div_done), 32'd0);
         adv();
      end
      wb_gnt = 1'b1;
      sample();
      chk("bp_done_on_gnt", 32'(div_done), 32'd1);
      adv();
      sample();
      chk("bp_done_once", 32'(div_done),   32'd0);
      chk("bp_idle",      32'(div_active), 32'd0);
      adv();

      // Stall paths, then back-to-back issue on the grant cycle.
      wb_gnt = 1'b0;
      found  = 1'b0;
      for (int c = 0; c < 40; c++) begin
         div_start = (c == 0) || (c == 5);
         remrd     = (c >= 5);
         sample();
         if (c == 5) begin
            chk("run_start_stall", 32'(start_stall), 32'd1);
            chk("run_rem_stall",   32'(rem_stall),   32'd1);
         end
         if (wb_req) begin found = 1'b1; break; end
         adv();
      end
      chk("stall_reach_wb", 32'(found), 32'd1);
      chk("wb_rem_stall_nogrant", 32'(rem_stall), 32'd1);
      adv();
      wb_gnt = 1'b1; div_start = 1'b1;
      sample();
      chk("gnt_rem_stall",   32'(rem_stall),   32'd0);
      chk("gnt_start_stall", 32'(start_stall), 32'd0);
      chk("gnt_done",        32'(div_done),    32'd1);
      adv();
      div_start = 1'b0; remrd = 1'b0;
      sample();
      chk("b2b_load", 32'(div_load), 32'd1);
      lat = 0;
      for (int c = 1; c < 40; c++) begin
         if (c > 1) sample();
         if (div_done) begin lat = c; break; end
         adv();
      end
      chk("b2b_latency", 32'(lat), 32'(STEPS + 2));
      adv();

      // Asynchronous reset mid-run.
      for (int c = 0; c < 10; c++) begin
         div_start = (c == 0);
         sample();
         if (c < 9) adv();
      end
      #2 reset_n = 1'b0;
      #1;
      chk("rst_load",   32'(div_load),   32'd0);
      chk("rst_step",   32'(div_step),   32'd0);
      chk("rst_cnt",    32'(div_cnt),    32'd0);
      chk("rst_active", 32'(div_active), 32'd0);
      chk("rst_wbreq",  32'(wb_req),     32'd0);
      chk("rst_done",   32'(div_done),   32'd0);
      chk("rst_offset", 32'(div_offset), 32'd0);
      model_reset();
      adv();
      sample();
      adv();
      reset_n = 1'b1;
      div_start = 1'b1;
      lat = 0;
      for (int c = 0; c < 40; c++) begin
         sample();
         if (div_done) begin lat = c; break; end
         adv();
         div_start = 1'b0;
      end
      chk("post_rst_latency", 32'(lat), 32'(STEPS + 2));
      adv();

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         div_start = ($urandom_range(3) == 0);
         wb_gnt    = ($urandom_range(2) != 0);
         divwr     = ($urandom_range(7) == 0);
         gpu_din   = $urandom;
         remrd     = ($urandom_range(3) == 0);
         sample();
         adv();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
